// File: rtl/fetch.sv
// Instruction-fetch stage with IF/ID register: single-outstanding req/gnt/rvalid
// fetch into a small instruction buffer that feeds decode one word per cycle.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        new_pc_en_i,
  input  logic [31:0] new_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_entry_pc;
  logic          r_outstanding;
  logic          r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_instr;
  logic [31:0]   r_pc_out;

  logic          w_live;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_grant;
  logic          w_push;
  logic          w_bypass;
  logic          w_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the live in-flight word so a grant can never overflow the buffer.
  assign w_live   = r_outstanding & ~r_discard;
  assign w_pop    = ~stall_i & ~flush_i & (r_count != '0);
  assign w_occ    = {1'b0, r_count} - (CW + 1)'(w_pop) + (CW + 1)'(w_live);
  assign w_req    = rstn_i & ~new_pc_en_i & (~r_outstanding | imem_rvalid_i) & (w_occ < DEPTH_C);
  assign w_grant  = w_req & imem_gnt_i;
  assign w_push   = imem_rvalid_i & ~r_discard & ~new_pc_en_i;
  // An empty buffer forwards the returning word straight into IF/ID.
  assign w_bypass = w_push & (r_count == '0) & ~stall_i & ~flush_i;
  assign w_wr     = w_push & ~w_bypass;

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign instr_o     = r_instr;
  assign pc_o        = r_pc_out;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pc          <= RESET_PC;
      r_entry_pc    <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      if (new_pc_en_i)  r_pc <= new_pc_i;
      else if (w_grant) r_pc <= r_pc + 32'd4;

      if (w_grant) begin
        r_outstanding <= 1'b1;
        r_discard     <= 1'b0;
        r_entry_pc    <= r_pc;
      end else if (imem_rvalid_i) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end else if (new_pc_en_i && r_outstanding) begin
        r_discard     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (new_pc_en_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]    <= r_entry_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_instr  <= NOP;
      r_pc_out <= '0;
    end else if (flush_i) begin
      r_instr  <= NOP;
      r_pc_out <= '0;
    end else if (stall_i) begin
      r_instr  <= r_instr;
      r_pc_out <= r_pc_out;
    end else if (r_count != '0) begin
      r_instr  <= r_fifo_instr[r_rd_ptr];
      r_pc_out <= r_fifo_pc[r_rd_ptr];
    end else if (w_bypass) begin
      r_instr  <= imem_rdata_i;
      r_pc_out <= r_entry_pc;
    end else begin
      r_instr  <= NOP;
      r_pc_out <= '0;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: memory handshake driven cycle by cycle, with
// hand-computed request, address and IF/ID expectations.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        npe;
  logic [31:0] npc;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .new_pc_en_i  (npe),
    .new_pc_i     (npc),
    .stall_i      (stall),
    .flush_i      (flush),
    .instr_o      (instr),
    .pc_o         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] m(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; request checked 1 ns later; IF/ID checked after the next posedge.
  task automatic cyc(input string tag, input logic g, input logic rv, input logic [31:0] rd,
                     input logic np_en, input logic [31:0] np, input logic st, input logic fl,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic [31:0] exp_instr, input logic [31:0] exp_pc);
    gnt = g; rvalid = rv; rdata = rd; npe = np_en; npc = np; stall = st; flush = fl;
    #1;
    chk({tag, ".req"}, {31'b0, req}, {31'b0, exp_req});
    if (exp_req) chk({tag, ".addr"}, addr, exp_addr);
    @(posedge clk);
    #1;
    chk({tag, ".instr"}, instr, exp_instr);
    chk({tag, ".pc"}, pc, exp_pc);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    gnt = 0; rvalid = 0; rdata = 0; npe = 0; npc = 0; stall = 0; flush = 0;
    #1;
    chk({tag, ".req"}, {31'b0, req}, 32'd0);
    chk({tag, ".instr"}, instr, NOP);
    chk({tag, ".pc"}, pc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    gnt = 0; rvalid = 0; rdata = 0; npe = 0; npc = 0; stall = 0; flush = 0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Streaming with 1-cycle memory
    cyc("a0", 1, 0, 0,               0, 0, 0, 0, 1, 32'h0,  NOP,       32'h0);
    cyc("a1", 1, 1, m(32'h0),        0, 0, 0, 0, 1, 32'h4,  m(32'h0),  32'h0);
    cyc("a2", 1, 1, m(32'h4),        0, 0, 0, 0, 1, 32'h8,  m(32'h4),  32'h4);
    cyc("a3", 1, 1, m(32'h8),        0, 0, 0, 0, 1, 32'hC,  m(32'h8),  32'h8);

    // Three-cycle stall fills the buffer and drops the request
    cyc("s1", 1, 1, m(32'hC),        0, 0, 1, 0, 1, 32'h10, m(32'h8),  32'h8);
    cyc("s2", 0, 1, m(32'h10),       0, 0, 1, 0, 0, 32'h0,  m(32'h8),  32'h8);
    cyc("s3", 0, 0, 0,               0, 0, 1, 0, 0, 32'h0,  m(32'h8),  32'h8);
    cyc("r1", 1, 0, 0,               0, 0, 0, 0, 1, 32'h14, m(32'hC),  32'hC);
    cyc("r2", 1, 1, m(32'h14),       0, 0, 0, 0, 1, 32'h18, m(32'h10), 32'h10);
    cyc("r3", 0, 1, m(32'h18),       0, 0, 0, 0, 1, 32'h1C, m(32'h14), 32'h14);
    cyc("r4", 0, 0, 0,               0, 0, 0, 0, 1, 32'h1C, m(32'h18), 32'h18);
    cyc("r5", 0, 0, 0,               0, 0, 0, 0, 1, 32'h1C, NOP,       32'h0);

    // Asynchronous reset in the middle of a stream
    do_reset("rst1");

    cyc("b0", 1, 0, 0,               0, 0, 0, 0, 1, 32'h0,  NOP,       32'h0);
    cyc("b1", 1, 1, m(32'h0),        0, 0, 0, 0, 1, 32'h4,  m(32'h0),  32'h0);
    cyc("b2", 1, 1, m(32'h4),        0, 0, 0, 0, 1, 32'h8,  m(32'h4),  32'h4);
    cyc("b3", 1, 1, m(32'h8),        0, 0, 0, 0, 1, 32'hC,  m(32'h8),  32'h8);
    cyc("b4", 1, 1, m(32'hC),        0, 0, 0, 0, 1, 32'h10, m(32'hC),  32'hC);
    // Redirect + flush while 0x10 is in flight; its response must be dropped
    cyc("b5", 1, 0, 0,               1, 32'h100, 0, 1, 0, 32'h0, NOP,  32'h0);
    cyc("b6", 1, 1, m(32'h10),       0, 0, 0, 0, 1, 32'h100, NOP,      32'h0);
    cyc("b7", 1, 1, m(32'h100),      0, 0, 0, 0, 1, 32'h104, m(32'h100), 32'h100);
    cyc("b8", 0, 1, m(32'h104),      0, 0, 0, 0, 1, 32'h108, m(32'h104), 32'h104);

    // Grant delayed two cycles, data three cycles after grant
    cyc("c0", 0, 0, 0,               0, 0, 0, 0, 1, 32'h108, NOP,      32'h0);
    cyc("c1", 0, 0, 0,               0, 0, 0, 0, 1, 32'h108, NOP,      32'h0);
    cyc("c2", 1, 0, 0,               0, 0, 0, 0, 1, 32'h108, NOP,      32'h0);
    cyc("c3", 0, 0, 0,               0, 0, 0, 0, 0, 32'h0,   NOP,      32'h0);
    cyc("c4", 0, 0, 0,               0, 0, 0, 0, 0, 32'h0,   NOP,      32'h0);
    cyc("c5", 0, 1, m(32'h108),      0, 0, 0, 0, 1, 32'h10C, m(32'h108), 32'h108);
    cyc("c6", 1, 0, 0,               0, 0, 0, 0, 1, 32'h10C, NOP,      32'h0);
    cyc("c7", 0, 0, 0,               0, 0, 0, 0, 0, 32'h0,   NOP,      32'h0);
    cyc("c8", 0, 0, 0,               0, 0, 0, 0, 0, 32'h0,   NOP,      32'h0);
    cyc("c9", 0, 1, m(32'h10C),      0, 0, 0, 0, 1, 32'h110, m(32'h10C), 32'h10C);

    // Buffer two words under stall, then a lone flush cycle
    cyc("d0", 1, 0, 0,               0, 0, 1, 0, 1, 32'h110, m(32'h10C), 32'h10C);
    cyc("d1", 1, 1, m(32'h110),      0, 0, 1, 0, 1, 32'h114, m(32'h10C), 32'h10C);
    cyc("d2", 0, 1, m(32'h114),      0, 0, 1, 0, 0, 32'h0,   m(32'h10C), 32'h10C);
    cyc("d3", 0, 0, 0,               0, 0, 0, 1, 0, 32'h0,   NOP,      32'h0);
    cyc("d4", 0, 0, 0,               0, 0, 0, 0, 1, 32'h118, m(32'h110), 32'h110);
    cyc("d5", 0, 0, 0,               0, 0, 0, 0, 1, 32'h118, m(32'h114), 32'h114);
    cyc("d6", 0, 0, 0,               0, 0, 0, 0, 1, 32'h118, NOP,      32'h0);

    // Redirect to the top word; next sequential address wraps to zero
    cyc("e0", 0, 0, 0,               1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, NOP, 32'h0);
    cyc("e1", 1, 0, 0,               0, 0, 0, 0, 1, 32'hFFFF_FFFC, NOP, 32'h0);
    cyc("e2", 0, 1, m(32'hFFFF_FFFC), 0, 0, 0, 0, 1, 32'h0, m(32'hFFFF_FFFC), 32'hFFFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
